// File: rtl/br_tag_alloc_if.sv
// Bundles the decode allocation handshake and the branch-resolution bus of the tag allocator.
// The master drives requests and resolutions; the slave is the allocator itself.
interface br_tag_alloc_if #(
  parameter int WIDTH_BRM = 4
);

  logic                 i_req;
  logic                 o_gnt;
  logic [WIDTH_BRM-1:0] o_tag;
  logic                 o_full;
  logic [WIDTH_BRM-1:0] o_cur_mask;

  logic                 i_valid;
  logic [WIDTH_BRM-1:0] i_brmask;
  logic                 i_brkill;
  logic [31:0]          i_PC;

  logic                 o_redirect;
  logic [31:0]          o_redirect_PC;
  logic [WIDTH_BRM-1:0] o_kill_mask;
  logic [WIDTH_BRM-1:0] o_clear_mask;

  modport master (
    output i_req, i_valid, i_brmask, i_brkill, i_PC,
    input  o_gnt, o_tag, o_full, o_cur_mask,
    input  o_redirect, o_redirect_PC, o_kill_mask, o_clear_mask
  );

  modport slave (
    input  i_req, i_valid, i_brmask, i_brkill, i_PC,
    output o_gnt, o_tag, o_full, o_cur_mask,
    output o_redirect, o_redirect_PC, o_kill_mask, o_clear_mask
  );

endinterface

// File: rtl/br_tag_alloc.sv
// Branch-tag allocator: hands out one-hot tags, tracks older-branch dependencies per tag,
// frees tags on correct resolution and squashes the mispredicted branch plus all younger ones.
module br_tag_alloc #(
  parameter int WIDTH_BRM = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  br_tag_alloc_if.slave  bus
);

  logic [WIDTH_BRM-1:0] r_busy;
  logic [WIDTH_BRM-1:0] r_dep [WIDTH_BRM];

  logic                 r_redirect;
  logic [31:0]          r_redirect_pc;
  logic [WIDTH_BRM-1:0] r_kill_mask;
  logic [WIDTH_BRM-1:0] r_clear_mask;

  logic                 w_hit;
  logic                 w_kill_now;
  logic                 w_clear_now;
  logic                 w_full;
  logic                 w_gnt;
  logic [WIDTH_BRM-1:0] w_free;
  logic [WIDTH_BRM-1:0] w_lowest;
  logic [WIDTH_BRM-1:0] w_tag;
  logic [WIDTH_BRM-1:0] w_kill_set;
  logic [WIDTH_BRM-1:0] w_free_mask;
  logic [WIDTH_BRM-1:0] w_busy_nxt;
  logic [WIDTH_BRM-1:0] w_dep_nxt [WIDTH_BRM];

  // A resolution only counts when it names a tag that is still in flight.
  assign w_hit       = |(bus.i_brmask & r_busy);
  assign w_kill_now  = bus.i_valid & w_hit & bus.i_brkill;
  assign w_clear_now = bus.i_valid & w_hit & ~bus.i_brkill;

  assign w_full   = &r_busy;
  assign w_gnt    = bus.i_req & ~w_full & ~w_kill_now;
  assign w_free   = ~r_busy;
  assign w_lowest = w_free & (-w_free);
  assign w_tag    = w_gnt ? w_lowest : '0;

  // Killed set: the resolving tag plus every live tag whose dependency set contains it.
  always_comb begin
    w_kill_set = bus.i_brmask;
    for (int t = 0; t < WIDTH_BRM; t++) begin
      if (r_busy[t] && |(r_dep[t] & bus.i_brmask)) begin
        w_kill_set[t] = 1'b1;
      end
    end
  end

  // Tags released this cycle are removed from the busy set and scrubbed from every dependency
  // set, so a tag allocated alongside a correct resolution never depends on the resolving branch.
  always_comb begin
    w_free_mask = '0;
    if (w_clear_now) begin
      w_free_mask = bus.i_brmask;
    end else if (w_kill_now) begin
      w_free_mask = w_kill_set;
    end
    w_busy_nxt = (r_busy & ~w_free_mask) | w_tag;
    for (int t = 0; t < WIDTH_BRM; t++) begin
      if (w_tag[t]) begin
        w_dep_nxt[t] = r_busy & ~w_free_mask;
      end else begin
        w_dep_nxt[t] = r_dep[t] & ~w_free_mask;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy        <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_kill_mask   <= '0;
      r_clear_mask  <= '0;
      for (int t = 0; t < WIDTH_BRM; t++) begin
        r_dep[t] <= '0;
      end
    end else begin
      r_busy       <= w_busy_nxt;
      r_redirect   <= w_kill_now;
      r_kill_mask  <= w_kill_now ? w_kill_set : '0;
      r_clear_mask <= w_clear_now ? bus.i_brmask : '0;
      if (w_kill_now) begin
        r_redirect_pc <= bus.i_PC;
      end
      for (int t = 0; t < WIDTH_BRM; t++) begin
        r_dep[t] <= w_dep_nxt[t];
      end
    end
  end

  assign bus.o_gnt         = w_gnt;
  assign bus.o_tag         = w_tag;
  assign bus.o_full        = w_full;
  assign bus.o_cur_mask    = r_busy;
  assign bus.o_redirect    = r_redirect;
  assign bus.o_redirect_PC = r_redirect_pc;
  assign bus.o_kill_mask   = r_kill_mask;
  assign bus.o_clear_mask  = r_clear_mask;

  a_brmask_onehot : assert property (@(posedge i_clk) disable iff (i_rst)
    bus.i_valid |-> $onehot(bus.i_brmask));

endmodule

// File: tb/tb_br_tag_alloc.sv
// Directed self-checking bench for br_tag_alloc with hand-computed expectations per scenario.
module tb_br_tag_alloc;

  logic i_clk;
  logic i_rst;
  int   checks;
  int   failures;

  br_tag_alloc_if #(.WIDTH_BRM(4)) bus ();

  br_tag_alloc #(.WIDTH_BRM(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req    = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_brmask = 4'b0000;
    bus.i_brkill = 1'b0;
    bus.i_PC     = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    #1;
  endtask

  task automatic alloc(input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_req = 1'b1;
      tick();
    end
    bus.i_req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    #2;
    checks++; if (bus.o_cur_mask !== 4'b0000) begin failures++; $display("[TB] FAIL reset_cur_mask got=%b exp=0000", bus.o_cur_mask); end
    checks++; if ({bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask} !== 9'b0) begin failures++; $display("[TB] FAIL reset_pulses got=%b/%b/%b exp=0", bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask); end
    checks++; if (bus.o_redirect_PC !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.o_redirect_PC); end
    checks++; if (bus.o_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", bus.o_full); end
    tick();
    i_rst = 1'b0;
    bus.i_req = 1'b1;
    #1;
    checks++; if ({bus.o_gnt, bus.o_tag} !== 5'b1_0001) begin failures++; $display("[TB] FAIL reset_gnt got=%b/%b exp=1/0001", bus.o_gnt, bus.o_tag); end
    bus.i_req = 1'b0;
    #1;
    checks++; if ({bus.o_gnt, bus.o_tag} !== 5'b0_0000) begin failures++; $display("[TB] FAIL reset_nogreq got=%b/%b exp=0/0000", bus.o_gnt, bus.o_tag); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_tag;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_tag = 4'b0001 << i;
      bus.i_req = 1'b1;
      #1;
      checks++; if ({bus.o_gnt, bus.o_tag} !== {1'b1, exp_tag}) begin failures++; $display("[TB] FAIL fill_gnt%0d got=%b/%b exp=1/%b", i, bus.o_gnt, bus.o_tag, exp_tag); end
      tick();
    end
    checks++; if ({bus.o_full, bus.o_gnt, bus.o_tag} !== 6'b1_0_0000) begin failures++; $display("[TB] FAIL fill_full got=%b/%b/%b exp=1/0/0000", bus.o_full, bus.o_gnt, bus.o_tag); end
    checks++; if (bus.o_cur_mask !== 4'b1111) begin failures++; $display("[TB] FAIL fill_cur_mask got=%b exp=1111", bus.o_cur_mask); end
    bus.i_req = 1'b0;
  endtask

  task automatic test_correct_resolve();
    do_reset();
    alloc(2);
    bus.i_valid  = 1'b1;
    bus.i_brmask = 4'b0001;
    bus.i_brkill = 1'b0;
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.o_clear_mask !== 4'b0001) begin failures++; $display("[TB] FAIL resolve_clear got=%b exp=0001", bus.o_clear_mask); end
    checks++; if (bus.o_cur_mask !== 4'b0010) begin failures++; $display("[TB] FAIL resolve_cur_mask got=%b exp=0010", bus.o_cur_mask); end
    checks++; if ({bus.o_redirect, bus.o_kill_mask} !== 5'b0) begin failures++; $display("[TB] FAIL resolve_no_kill got=%b/%b exp=0/0000", bus.o_redirect, bus.o_kill_mask); end
    bus.i_req = 1'b1;
    #1;
    checks++; if ({bus.o_gnt, bus.o_tag} !== 5'b1_0001) begin failures++; $display("[TB] FAIL resolve_regrant got=%b/%b exp=1/0001", bus.o_gnt, bus.o_tag); end
    tick();
    bus.i_req = 1'b0;
    checks++; if ({bus.o_clear_mask, bus.o_cur_mask} !== 8'b0000_0011) begin failures++; $display("[TB] FAIL resolve_pulse_end got=%b/%b exp=0000/0011", bus.o_clear_mask, bus.o_cur_mask); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(3);
    bus.i_valid  = 1'b1;
    bus.i_brmask = 4'b0010;
    bus.i_brkill = 1'b1;
    bus.i_PC     = 32'h0000_0040;
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.o_redirect !== 1'b1) begin failures++; $display("[TB] FAIL kill_redirect got=%b exp=1", bus.o_redirect); end
    checks++; if (bus.o_redirect_PC !== 32'h0000_0040) begin failures++; $display("[TB] FAIL kill_pc got=%h exp=00000040", bus.o_redirect_PC); end
    checks++; if (bus.o_kill_mask !== 4'b0110) begin failures++; $display("[TB] FAIL kill_mask got=%b exp=0110", bus.o_kill_mask); end
    checks++; if ({bus.o_cur_mask, bus.o_clear_mask} !== 8'b0001_0000) begin failures++; $display("[TB] FAIL kill_cur_mask got=%b/%b exp=0001/0000", bus.o_cur_mask, bus.o_clear_mask); end
    tick();
    checks++; if ({bus.o_redirect, bus.o_kill_mask} !== 5'b0) begin failures++; $display("[TB] FAIL kill_pulse_end got=%b/%b exp=0/0000", bus.o_redirect, bus.o_kill_mask); end
  endtask

  task automatic test_kill_with_req();
    do_reset();
    alloc(3);
    bus.i_req    = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_brmask = 4'b0001;
    bus.i_brkill = 1'b1;
    bus.i_PC     = 32'h0000_1000;
    #1;
    checks++; if ({bus.o_gnt, bus.o_tag} !== 5'b0_0000) begin failures++; $display("[TB] FAIL killreq_suppressed got=%b/%b exp=0/0000", bus.o_gnt, bus.o_tag); end
    tick();
    bus.i_valid  = 1'b0;
    bus.i_brmask = 4'b0000;
    bus.i_brkill = 1'b0;
    #1;
    checks++; if ({bus.o_redirect, bus.o_kill_mask, bus.o_cur_mask} !== 9'b1_0111_0000) begin failures++; $display("[TB] FAIL killreq_result got=%b/%b/%b exp=1/0111/0000", bus.o_redirect, bus.o_kill_mask, bus.o_cur_mask); end
    checks++; if ({bus.o_gnt, bus.o_tag} !== 5'b1_0001) begin failures++; $display("[TB] FAIL killreq_retry got=%b/%b exp=1/0001", bus.o_gnt, bus.o_tag); end
    tick();
    bus.i_req = 1'b0;
    checks++; if (bus.o_cur_mask !== 4'b0001) begin failures++; $display("[TB] FAIL killreq_cur_mask got=%b exp=0001", bus.o_cur_mask); end
  endtask

  task automatic test_stale();
    do_reset();
    alloc(2);
    bus.i_valid  = 1'b1;
    bus.i_brmask = 4'b1000;
    bus.i_brkill = 1'b1;
    bus.i_PC     = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    #1;
    checks++; if ({bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask} !== 9'b0) begin failures++; $display("[TB] FAIL stale_pulses got=%b/%b/%b exp=0", bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask); end
    checks++; if (bus.o_cur_mask !== 4'b0011) begin failures++; $display("[TB] FAIL stale_cur_mask got=%b exp=0011", bus.o_cur_mask); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc(3);
    bus.i_req    = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_brmask = 4'b0001;
    bus.i_brkill = 1'b0;
    #1;
    checks++; if ({bus.o_gnt, bus.o_tag} !== 5'b1_1000) begin failures++; $display("[TB] FAIL b2b_alloc got=%b/%b exp=1/1000", bus.o_gnt, bus.o_tag); end
    tick();
    bus.i_req    = 1'b0;
    bus.i_brmask = 4'b0010;
    bus.i_brkill = 1'b1;
    bus.i_PC     = 32'h0000_1234;
    #1;
    checks++; if ({bus.o_clear_mask, bus.o_cur_mask} !== 8'b0001_1110) begin failures++; $display("[TB] FAIL b2b_clear got=%b/%b exp=0001/1110", bus.o_clear_mask, bus.o_cur_mask); end
    tick();
    idle_inputs();
    #1;
    checks++; if ({bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask} !== 9'b1_1110_0000) begin failures++; $display("[TB] FAIL b2b_kill got=%b/%b/%b exp=1/1110/0000", bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask); end
    checks++; if ({bus.o_cur_mask, bus.o_redirect_PC} !== {4'b0000, 32'h0000_1234}) begin failures++; $display("[TB] FAIL b2b_state got=%b/%h exp=0000/00001234", bus.o_cur_mask, bus.o_redirect_PC); end
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    alloc(2);
    bus.i_valid  = 1'b1;
    bus.i_brmask = 4'b0010;
    bus.i_brkill = 1'b1;
    bus.i_PC     = 32'h0000_0080;
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.o_redirect !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre got=%b exp=1", bus.o_redirect); end
    i_rst = 1'b1;
    #1;
    checks++; if ({bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask, bus.o_cur_mask} !== 13'b0) begin failures++; $display("[TB] FAIL midrst_clear got=%b/%b/%b/%b exp=0", bus.o_redirect, bus.o_kill_mask, bus.o_clear_mask, bus.o_cur_mask); end
    checks++; if ({bus.o_redirect_PC, bus.o_full} !== 33'b0) begin failures++; $display("[TB] FAIL midrst_pc got=%h/%b exp=0/0", bus.o_redirect_PC, bus.o_full); end
    i_rst = 1'b0;
    bus.i_req = 1'b1;
    #1;
    checks++; if ({bus.o_gnt, bus.o_tag} !== 5'b1_0001) begin failures++; $display("[TB] FAIL midrst_gnt got=%b/%b exp=1/0001", bus.o_gnt, bus.o_tag); end
    bus.i_req = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_correct_resolve();
    test_mispredict();
    test_kill_with_req();
    test_stale();
    test_back_to_back();
    test_reset_mid_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
